// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the IO page: register indices, STATUS bit layout and
// the UART serializer state encoding.
package io_pkg;

  localparam logic [1:0] IO_LEDS        = 2'd0;
  localparam logic [1:0] IO_UART_DATA   = 2'd1;
  localparam logic [1:0] IO_UART_STATUS = 2'd2;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_FULL = 1;
  localparam int unsigned STAT_OVF  = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_t;

  function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                              input logic busy);
    status_word            = '0;
    status_word[STAT_OVF]  = ovf;
    status_word[STAT_FULL] = full;
    status_word[STAT_BUSY] = busy;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_serializer.sv
// 8N1 transmit serializer: takes one byte per valid/ready handshake and shifts
// it out LSB first, one bit per DIV clocks, with registered TXD.
module uart_tx_serializer
  import io_pkg::*;
#(
  parameter int unsigned DIV = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  ser_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          txd_n;
  logic          tick;

  assign tick  = (cnt == LAST);
  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
    end
  end

  // shift[0] always holds the next data bit to be driven
  always_comb begin
    state_n   = state;
    cnt_n     = tick ? '0 : cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    txd_n     = txd;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (valid) begin
          state_n   = START;
          cnt_n     = '0;
          bit_idx_n = '0;
          shift_n   = data;
          txd_n     = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          txd_n   = shift[0];
          shift_n = {1'b0, shift[7:1]};
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txd_n     = shift[0];
            shift_n   = {1'b0, shift[7:1]};
          end
        end
      end
      STOP: begin
        txd_n = 1'b1;
        if (tick) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// IO page slave: LED register and polled transmit-only UART with one-cycle read
// latency. Define IO_UART_FIFO_EN for a FIFO_DEPTH-entry TX FIFO, else one holding register.
module mmio_uart_tx
  import io_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned IO_BIT      = 22
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] io_rdata,
  output logic [3:0]  LEDS,
  output logic        TXD
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;

  logic       io_sel;
  logic [1:0] reg_idx;
  logic       wr;
  logic       push, push_ok, pop, clr_ovf;
  logic       full, empty;
  logic [7:0] head;
  logic       overflow;
  logic       ser_ready, ser_busy;
  logic       unused_bits;

  assign io_sel  = mem_addr[IO_BIT];
  assign reg_idx = mem_addr[3:2];
  assign wr      = io_sel & mem_wmask[0];
  assign push    = wr & (reg_idx == IO_UART_DATA);
  assign clr_ovf = wr & (reg_idx == IO_UART_STATUS);
  assign pop     = !empty & ser_ready;
  // A full buffer still takes a byte when the serializer drains one this cycle
  assign push_ok = push & (!full | pop);

  assign unused_bits = ^{mem_addr, mem_wdata[31:8], mem_wmask[3:1], FIFO_DEPTH == 0};

`ifdef IO_UART_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = fifo_mem[rptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push_ok) fifo_mem[wptr[AW-1:0]] <= mem_wdata[7:0];
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  assign empty = !hold_valid;
  assign full  = hold_valid;
  assign head  = hold_data;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push_ok) begin
      hold_valid <= 1'b1;
      hold_data  <= mem_wdata[7:0];
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      LEDS     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr && reg_idx == IO_LEDS) LEDS <= mem_wdata[3:0];
      if (clr_ovf)                  overflow <= 1'b0;
      else if (push && !push_ok)    overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      io_rdata <= '0;
    end else if (io_sel && mem_rstrb) begin
      case (reg_idx)
        IO_LEDS:        io_rdata <= {28'b0, LEDS};
        IO_UART_STATUS: io_rdata <= status_word(overflow, full, !empty | ser_busy);
        default:        io_rdata <= '0;
      endcase
    end
  end

  uart_tx_serializer #(
    .DIV(DIV)
  ) u_ser (
    .clk   (CLK),
    .resetn(RESETN),
    .valid (!empty),
    .data  (head),
    .ready (ser_ready),
    .txd   (TXD),
    .busy  (ser_busy)
  );

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with DIV=8; bus driven and outputs sampled on negedge.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_LEDS = 32'h0040_0000;
  localparam logic [31:0] A_DATA = 32'h0040_0004;
  localparam logic [31:0] A_STAT = 32'h0040_0008;
  localparam logic [31:0] A_RSVD = 32'h0040_000C;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] io_rdata;
  logic [3:0]  LEDS;
  logic        TXD;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mmio_uart_tx #(
    .CLK_FREQ_HZ(8),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (4),
    .IO_BIT     (22)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .io_rdata (io_rdata),
    .LEDS     (LEDS),
    .TXD      (TXD)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
    mem_addr  = addr;
    mem_wdata = data;
    mem_wmask = mask;
    @(negedge CLK);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    mem_addr  = addr;
    mem_rstrb = 1'b1;
    @(negedge CLK);
    mem_rstrb = 1'b0;
    mem_addr  = '0;
    d = io_rdata;
  endtask

  // Call at the negedge right after the push edge; checks all 80 frame cycles.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic [31:0] exp;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp = 32'd0;
      else if (i == 9) exp = 32'd1;
      else             exp = {31'b0, b[i-1]};
      for (int c = 0; c < 8; c++) begin
        @(negedge CLK);
        check_eq($sformatf("%s bit%0d cyc%0d", tag, i, c), {31'b0, TXD}, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  q [5];
    logic        saw_low;
    q[0] = 8'h01; q[1] = 8'h82; q[2] = 8'hC3; q[3] = 8'h3C; q[4] = 8'hA5;

    // power-on reset
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    check_eq("por txd", {31'b0, TXD}, 32'd1);
    check_eq("por leds", {28'b0, LEDS}, 32'd0);
    check_eq("por rdata", io_rdata, 32'd0);
    bus_read(A_STAT, d);
    check_eq("por status", d, 32'd0);

    // LEDS byte-lane gating and readback
    bus_write(A_LEDS, 32'h0000_000A, 4'b0001);
    check_eq("leds write", {28'b0, LEDS}, 32'hA);
    bus_write(A_LEDS, 32'h0000_0005, 4'b0010);
    check_eq("leds masked", {28'b0, LEDS}, 32'hA);
    bus_write(A_RSVD, 32'h0000_0003, 4'b0001);
    check_eq("leds rsvd wr", {28'b0, LEDS}, 32'hA);
    bus_read(A_RSVD, d);
    check_eq("rsvd read", d, 32'd0);
    bus_read(A_LEDS, d);
    check_eq("leds read", d, 32'hA);

    // accesses outside the IO page
    bus_write(32'h0000_0000, 32'h0000_0003, 4'b0001);
    check_eq("nosel leds", {28'b0, LEDS}, 32'hA);
    bus_write(32'h0000_0004, 32'h0000_0077, 4'b0001);
    repeat (2) @(negedge CLK);
    check_eq("nosel txd", {31'b0, TXD}, 32'd1);
    bus_read(32'h0000_0008, d);
    check_eq("nosel rdata hold", io_rdata, 32'hA);
    bus_read(A_STAT, d);
    check_eq("nosel no push", d, 32'd0);

    // single frame 0x55 and busy release boundary
    bus_write(A_DATA, 32'h0000_0055, 4'b0001);
    expect_frame(8'h55, "f55");
    bus_read(A_STAT, d);
    check_eq("busy at stop end", d, 32'd1);
    bus_read(A_STAT, d);
    check_eq("idle after frame", d, 32'd0);

`ifdef IO_UART_FIFO_EN
    fork
      begin
        for (int i = 0; i < 5; i++) bus_write(A_DATA, {24'b0, q[i]}, 4'b0001);
        bus_write(A_DATA, 32'h0000_00FF, 4'b0001);
        bus_read(A_STAT, d);
        check_eq("fifo ovf status", d, 32'h7);
        bus_write(A_STAT, 32'h0, 4'b0001);
        bus_read(A_STAT, d);
        check_eq("fifo ovf cleared", d, 32'h3);
      end
      begin
        @(negedge CLK);
        expect_frame(q[0], "fifo b1");
        for (int j = 1; j < 5; j++) begin
          @(negedge CLK);
          check_eq($sformatf("fifo gap%0d", j), {31'b0, TXD}, 32'd1);
          expect_frame(q[j], $sformatf("fifo b%0d", j + 1));
        end
      end
    join
`else
    fork
      begin
        bus_write(A_DATA, 32'h0000_0041, 4'b0001);
        bus_write(A_DATA, 32'h0000_0042, 4'b0001);
        bus_write(A_DATA, 32'h0000_0043, 4'b0001);
        bus_read(A_STAT, d);
        check_eq("hold ovf status", d, 32'h7);
        bus_write(A_STAT, 32'h0, 4'b0001);
        bus_read(A_STAT, d);
        check_eq("hold ovf cleared", d, 32'h3);
      end
      begin
        @(negedge CLK);
        expect_frame(8'h41, "hold 41");
        @(negedge CLK);
        check_eq("hold gap", {31'b0, TXD}, 32'd1);
        expect_frame(8'h42, "hold 42");
      end
    join
`endif
    @(negedge CLK);
    bus_read(A_STAT, d);
    check_eq("drained", d, 32'd0);

    // reset in the middle of a frame
    bus_read(A_LEDS, d);
    bus_write(A_DATA, 32'h0000_0033, 4'b0001);
    repeat (20) @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    check_eq("rst txd", {31'b0, TXD}, 32'd1);
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    check_eq("rst leds", {28'b0, LEDS}, 32'd0);
    check_eq("rst rdata", io_rdata, 32'd0);
    saw_low = 1'b0;
    repeat (90) begin
      @(negedge CLK);
      if (TXD !== 1'b1) saw_low = 1'b1;
    end
    check_eq("rst no resume", {31'b0, saw_low}, 32'd0);
    bus_read(A_STAT, d);
    check_eq("rst status", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
